// File: rtl/pipe_ctrl.sv
// Pipeline control: stall bus from per-stage requests, flush/redirect FSM, stall accounting.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WDT_EN.
module pipe_ctrl #(
    parameter int unsigned NUM_STAGES   = 5,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WDT_LIMIT    = 1023
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [NUM_STAGES-1:0] stallreq,
    input  logic                  flush_req,
    input  logic [31:0]           flush_pc,
    output logic [NUM_STAGES:0]   stall,
    output logic [NUM_STAGES:0]   flush,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic                  busy,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic                  wdt_timeout
);

    localparam int unsigned HOLD_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15) begin : g_bad_flush_cycles
        $error("pipe_ctrl: FLUSH_CYCLES must be within 1..15");
    end
    if (WDT_LIMIT < 1) begin : g_bad_wdt_limit
        $error("pipe_ctrl: WDT_LIMIT must be at least 1");
    end

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_nxt;
    logic                  w_capture;
    logic [31:0]           r_redirect_pc;
    logic [CNT_W-1:0]      r_stall_cnt;
    logic [NUM_STAGES:0]   w_stall_req;
    logic                  w_any;
    logic                  w_stall_cycle;
    logic                  w_wdt;

    // Stage k holding also holds every older stage and the PC.
    always_comb begin
        w_stall_req = '0;
        w_any       = 1'b0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            w_any              = w_any | stallreq[i];
            w_stall_req[i + 1] = w_any;
        end
        w_stall_req[0] = w_any;
    end

    assign w_stall_cycle = (r_state == ST_IDLE) && w_stall_req[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_IDLE;
            r_hold_cnt    <= '0;
            r_redirect_pc <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            if (w_capture) begin
                r_redirect_pc <= flush_pc;
            end
        end
    end

    // A new flush request always wins, restarting the flush from any state.
    always_comb begin
        w_state_nxt    = r_state;
        w_hold_nxt     = r_hold_cnt;
        w_capture      = 1'b0;
        stall          = '0;
        flush          = '0;
        redirect_valid = 1'b0;
        busy           = 1'b0;
        if (flush_req) begin
            w_state_nxt = ST_FLUSH;
            w_hold_nxt  = HOLD_W'(FLUSH_CYCLES - 1);
            w_capture   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nxt = ST_IDLE;
                ST_FLUSH: begin
                    if (r_hold_cnt == '0) begin
                        w_state_nxt = ST_REDIRECT;
                    end else begin
                        w_hold_nxt = r_hold_cnt - HOLD_W'(1);
                    end
                end
                ST_REDIRECT: w_state_nxt = ST_IDLE;
                default:     w_state_nxt = ST_IDLE;
            endcase
        end
        case (r_state)
            ST_IDLE: begin
                stall = w_wdt ? '0 : w_stall_req;
            end
            ST_FLUSH: begin
                flush = '1;
                busy  = 1'b1;
            end
            ST_REDIRECT: begin
                flush[0]       = 1'b1;
                busy           = 1'b1;
                redirect_valid = !flush_req;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Counts requested stall cycles, so it keeps running while the watchdog masks stall.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= '0;
        end else if (w_stall_cycle && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

`ifdef PIPE_CTRL_STALL_WDT_EN
    localparam int unsigned WDT_W = $clog2(WDT_LIMIT + 1);

    logic [WDT_W-1:0] r_wdt_cnt;
    logic             r_wdt;

    // Consecutive-stall watchdog; the flag is sticky until reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wdt_cnt <= '0;
            r_wdt     <= 1'b0;
        end else if (!w_stall_cycle) begin
            r_wdt_cnt <= '0;
        end else if (!r_wdt) begin
            r_wdt_cnt <= r_wdt_cnt + WDT_W'(1);
            if (r_wdt_cnt == WDT_W'(WDT_LIMIT - 1)) begin
                r_wdt <= 1'b1;
            end
        end
    end

    assign w_wdt       = r_wdt;
    assign wdt_timeout = r_wdt;
`else
    assign w_wdt       = 1'b0;
    assign wdt_timeout = 1'b0;
`endif

    assign redirect_pc = r_redirect_pc;
    assign stall_cnt   = r_stall_cnt;

endmodule
